// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline register, byte-lane data memory with store commit, and the combinational load port
module memory_stage #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_execute,
  input  logic [31:0] instr_execute,
  input  logic        reg_file_en_i,
  input  logic        mem_en_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] pc_memory,
  output logic [31:0] instr_o,
  output logic        reg_file_en_o,
  output logic        mem_en_o,
  output logic [31:0] mem_data_adres_o,
  output logic [31:0] alu_out_o,
  input  logic [31:0] load_adres,
  output logic [31:0] load_mem_data,
  output logic        misalign_o,
  output logic [15:0] store_cnt_o
);
  logic [31:0]       mem [DEPTH];
  logic [31:0]       store_data;
  logic              committed;
  logic              live;
  logic              attempt;
  logic              misaligned;
  logic              we;
  logic [2:0]        funct3;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       load_word;
  logic              unused_bits;
  // Decode the store sitting in MEM into a byte-enable write; flush kills it before it commits
  always_comb begin
    funct3     = instr_o[14:12];
    lane       = alu_out_o[1:0];
    widx       = alu_out_o[ADDR_W+1:2];
    live       = mem_en_o && (instr_o[6:0] == 7'b0100011);
    attempt    = live && !committed && !flush_i;
    misaligned = ((funct3 == 3'b001) && lane[0]) || ((funct3 == 3'b010) && (lane != 2'b00));
    be         = (funct3 == 3'b000) ? (4'b0001 << lane) :
                 (funct3 == 3'b001) ? (4'b0011 << lane) :
                 (funct3 == 3'b010) ? 4'b1111 : 4'b0000;
    wdata      = (funct3 == 3'b000) ? {4{store_data[7:0]}} :
                 (funct3 == 3'b001) ? {2{store_data[15:0]}} : store_data;
    we         = attempt && !misaligned && (be != 4'b0000);
  end
  // Pipeline register with flush > stall > capture priority, plus commit bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_memory        <= '0;
      instr_o          <= '0;
      reg_file_en_o    <= 1'b0;
      mem_en_o         <= 1'b0;
      mem_data_adres_o <= '0;
      alu_out_o        <= '0;
      store_data       <= '0;
      committed        <= 1'b0;
      misalign_o       <= 1'b0;
      store_cnt_o      <= '0;
    end else begin
      misalign_o  <= attempt && misaligned;
      store_cnt_o <= store_cnt_o + 16'(we);
      if (flush_i) begin
        pc_memory        <= '0;
        instr_o          <= '0;
        reg_file_en_o    <= 1'b0;
        mem_en_o         <= 1'b0;
        mem_data_adres_o <= '0;
        alu_out_o        <= '0;
        store_data       <= '0;
        committed        <= 1'b0;
      end else if (stall_i) begin
        committed <= committed || attempt;
      end else begin
        pc_memory        <= pc_execute;
        instr_o          <= instr_execute;
        reg_file_en_o    <= reg_file_en_i;
        mem_en_o         <= mem_en_i;
        mem_data_adres_o <= mem_en_i ? alu_out_i : 32'h0;
        alu_out_o        <= alu_out_i;
        store_data       <= store_data_i;
        committed        <= 1'b0;
      end
    end
  end
  // Byte-lane memory write; contents survive reset and no write happens while it is held
  always_ff @(posedge clk_i) begin
    if (we && !rst_i)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
  end
  // Combinational load: word lookup then right-align the addressed byte, zero-filled
  always_comb begin
    load_word     = mem[load_adres[ADDR_W+1:2]];
    load_mem_data = load_word >> {load_adres[1:0], 3'b000};
    unused_bits   = ^load_adres[31:ADDR_W+2];
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed stimulus against a byte-array model of the MEM stage, checked every falling edge
module tb_memory_stage;
  localparam int DEPTH = 512;
  localparam int ADDR_W = 9;
  localparam int BYTES = DEPTH * 4;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_execute;
  logic [31:0] instr_execute;
  logic        reg_file_en_i;
  logic        mem_en_i;
  logic [31:0] alu_out_i;
  logic [31:0] store_data_i;
  logic [31:0] pc_memory;
  logic [31:0] instr_o;
  logic        reg_file_en_o;
  logic        mem_en_o;
  logic [31:0] mem_data_adres_o;
  logic [31:0] alu_out_o;
  logic [31:0] load_adres;
  logic [31:0] load_mem_data;
  logic        misalign_o;
  logic [15:0] store_cnt_o;
  memory_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_execute(pc_execute), .instr_execute(instr_execute),
    .reg_file_en_i(reg_file_en_i), .mem_en_i(mem_en_i),
    .alu_out_i(alu_out_i), .store_data_i(store_data_i),
    .pc_memory(pc_memory), .instr_o(instr_o), .reg_file_en_o(reg_file_en_o),
    .mem_en_o(mem_en_o), .mem_data_adres_o(mem_data_adres_o), .alu_out_o(alu_out_o),
    .load_adres(load_adres), .load_mem_data(load_mem_data),
    .misalign_o(misalign_o), .store_cnt_o(store_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc = 0, m_instr = 0, m_alu = 0, m_sd = 0, m_adr = 0;
  logic        m_rfe = 0, m_me = 0, m_done = 0, m_mis = 0;
  int          m_cnt = 0;
  logic [7:0]  mb [BYTES];
  bit          kn [BYTES];
  task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task mreset();
    m_pc = 0; m_instr = 0; m_alu = 0; m_sd = 0; m_adr = 0;
    m_rfe = 0; m_me = 0; m_done = 0; m_mis = 0; m_cnt = 0;
  endtask
  function automatic logic [31:0] mload(input logic [31:0] a, output bit ok);
    int base;
    logic [31:0] w;
    base = int'(a % BYTES) & ~3;
    ok = kn[base] && kn[base+1] && kn[base+2] && kn[base+3];
    w = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    return w >> (8 * int'(a[1:0]));
  endfunction
  task automatic step();
    int f3;
    int ba;
    bit att;
    bit mis;
    if (rst_i) begin
      mreset();
      return;
    end
    f3 = int'(m_instr[14:12]);
    att = m_me && (m_instr[6:0] == 7'h23) && !m_done && !flush_i;
    mis = 0;
    if (att) begin
      mis = (f3 == 1 && m_alu[0]) || (f3 == 2 && m_alu[1:0] != 2'b00);
      if (f3 <= 2 && !mis) begin
        ba = int'(m_alu % BYTES);
        for (int k = 0; k < (1 << f3); k++) begin
          mb[ba+k] = m_sd[8*k +: 8];
          kn[ba+k] = 1;
        end
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
    m_mis = att && mis;
    if (flush_i) begin
      m_pc = 0; m_instr = 0; m_alu = 0; m_sd = 0; m_adr = 0;
      m_rfe = 0; m_me = 0; m_done = 0;
    end else if (stall_i) begin
      m_done = m_done || att;
    end else begin
      m_pc = pc_execute; m_instr = instr_execute; m_alu = alu_out_i; m_sd = store_data_i;
      m_adr = mem_en_i ? alu_out_i : 32'h0;
      m_rfe = reg_file_en_i; m_me = mem_en_i; m_done = 0;
    end
  endtask
  always @(negedge clk_i) begin
    bit ok;
    logic [31:0] ld;
    chk("pc_memory", pc_memory, m_pc);
    chk("instr_o", instr_o, m_instr);
    chk("reg_file_en_o", {31'b0, reg_file_en_o}, {31'b0, m_rfe});
    chk("mem_en_o", {31'b0, mem_en_o}, {31'b0, m_me});
    chk("mem_data_adres_o", mem_data_adres_o, m_adr);
    chk("alu_out_o", alu_out_o, m_alu);
    chk("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
    chk("store_cnt_o", {16'b0, store_cnt_o}, 32'(m_cnt));
    ld = mload(load_adres, ok);
    if (ok) chk("load_mem_data", load_mem_data, ld);
  end
  task tick();
    @(posedge clk_i);
    step();
    #1;
  endtask
  task drv(input logic [31:0] pc, input logic [31:0] ins, input logic rfe, input logic me,
           input logic [31:0] alu, input logic [31:0] sd, input logic st, input logic fl);
    pc_execute = pc; instr_execute = ins; reg_file_en_i = rfe; mem_en_i = me;
    alu_out_i = alu; store_data_i = sd; stall_i = st; flush_i = fl;
  endtask
  task st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    drv(pc, {17'b0, f3, 5'b0, 7'h23}, 1'b0, 1'b1, a, d, 1'b0, 1'b0);
    tick();
  endtask
  task bub();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
  task ld_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    load_adres = a;
    @(negedge clk_i);
    chk(nm, load_mem_data, exp);
  endtask
  initial begin
    rst_i = 1'b1;
    load_adres = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset cnt", {16'b0, store_cnt_o}, 32'h0);
    chk("reset pc", pc_memory, 32'h0);
    st(3'b010, 32'h10, 32'hDEADBEEF, 32'h100);
    @(negedge clk_i);
    chk("capture pc", pc_memory, 32'h100);
    chk("capture adres", mem_data_adres_o, 32'h10);
    bub();
    ld_chk("sw ld 0x10", 32'h10, 32'hDEADBEEF);
    ld_chk("sw ld 0x11", 32'h11, 32'h00DEADBE);
    ld_chk("sw ld 0x13", 32'h13, 32'h000000DE);
    chk("sw cnt", {16'b0, store_cnt_o}, 32'd1);
    st(3'b010, 32'h20, 32'h11223344, 32'h104);
    bub();
    st(3'b000, 32'h21, 32'h000000AA, 32'h108);
    bub();
    ld_chk("sb word", 32'h20, 32'h1122AA44);
    chk("sb cnt", {16'b0, store_cnt_o}, 32'd3);
    st(3'b001, 32'h23, 32'h0000BEEF, 32'h10C);
    bub();
    @(negedge clk_i);
    chk("sh misalign pulse", {31'b0, misalign_o}, 32'd1);
    chk("sh misalign cnt", {16'b0, store_cnt_o}, 32'd3);
    bub();
    @(negedge clk_i);
    chk("sh misalign drop", {31'b0, misalign_o}, 32'd0);
    ld_chk("sh mem unchanged", 32'h20, 32'h1122AA44);
    st(3'b010, 32'h30, 32'hCAFEF00D, 32'h200);
    drv(32'h999, 32'h00002023, 1'b1, 1'b1, 32'h70, 32'hFFFFFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_i);
      chk("stall pc", pc_memory, 32'h200);
      chk("stall cnt", {16'b0, store_cnt_o}, 32'd4);
    end
    bub();
    ld_chk("stall word", 32'h30, 32'hCAFEF00D);
    chk("stall cnt after", {16'b0, store_cnt_o}, 32'd4);
    st(3'b010, 32'h40, 32'h00000000, 32'h300);
    bub();
    st(3'b010, 32'h40, 32'h12345678, 32'h304);
    drv(32'h308, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    tick();
    @(negedge clk_i);
    chk("flush mem_en", {31'b0, mem_en_o}, 32'd0);
    chk("flush pc", pc_memory, 32'h0);
    chk("flush cnt", {16'b0, store_cnt_o}, 32'd5);
    bub();
    ld_chk("flush word", 32'h40, 32'h0);
    st(3'b010, BYTES + 32'h50, 32'h0BADF00D, 32'h400);
    bub();
    ld_chk("wrap word", 32'h50, 32'h0BADF00D);
    ld_chk("wrap byte", 32'h52, 32'h00000BAD);
    chk("wrap cnt", {16'b0, store_cnt_o}, 32'd6);
    st(3'b010, 32'h60, 32'h01020304, 32'h500);
    bub();
    st(3'b010, 32'h60, 32'h55555555, 32'h504);
    rst_i = 1'b1;
    #1;
    chk("midrst mem_en", {31'b0, mem_en_o}, 32'd0);
    chk("midrst pc", pc_memory, 32'h0);
    chk("midrst cnt", {16'b0, store_cnt_o}, 32'd0);
    mreset();
    tick();
    rst_i = 1'b0;
    bub();
    ld_chk("midrst word", 32'h60, 32'h01020304);
    chk("midrst cnt after", {16'b0, store_cnt_o}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
